sha256_msg_sched: RTL and testbench

Sequential SHA-256 message-schedule generator (FIPS 180-4). It accepts the 16 32-bit words of one 512-bit message block over a valid/ready input stream and emits the 64 schedule words W[0..63] over a valid/ready output stream. It uses one 16-word sliding window, with `sigma0` and `sigma1` instances computing the expansion. It sits between the block padder/loader and the compression-round core, and is the consumer of the sigma functions' outputs.

---
 rtl/sha256_msg_sched.sv | 82 ++++++++
 tb/tb_sha256_msg_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator: loads a 16-word block, then streams W[0..63]
// out of a 16-word sliding window that extends itself with the sigma recurrence.
module sha256_msg_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        out_last
);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [5:0]  t;
  logic [31:0] win [16];
  logic [31:0] w_next;
  logic        in_fire, out_fire;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Handshake flags depend on state only, so no input reaches an output combinationally.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 4'd15) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && t == 6'd63) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
  end

  // Keeps running past t=47; those words are never shown since only win[0] is output.
  assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      t   <= 6'd0;
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
    end else if (in_fire) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= in_word;
      cnt     <= (cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
      t       <= 6'd0;
    end else if (out_fire) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_next;
      t       <= (t == 6'd63) ? 6'd0 : t + 6'd1;
    end
  end

  assign out_word = win[0];
  assign out_idx  = t;
  assign out_last = (t == 6'd63);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: a software schedule model queues the expected
// words per block, and the drain loop compares every output transfer against it.
module tb_sha256_msg_sched;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        out_last;

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] blk [16];

  sha256_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected schedule for the current block; the "abc" block also pins the FIPS words W16/W17.
  task automatic push_golden(input bit abc);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
    if (abc) begin
      w[16] = 32'h61626380;
      w[17] = 32'h000F0000;
    end
    for (int i = 0; i < 64; i++) begin
      e.word = w[i];
      e.idx  = i[5:0];
      e.last = (i == 63);
      sb.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input int n, input bit gaps, input bit abc);
    if (n == 16) push_golden(abc);
    for (int i = 0; i < n; ) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_word  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_word  = blk[i];
        check("in_ready during load", {31'd0, in_ready}, 32'd1);
        i++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_output(input int n, input bit stalls, input bit junk);
    int          got = 0;
    int          budget = 0;
    bit          stalled;
    logic [31:0] hold_w;
    logic [5:0]  hold_i;
    exp_t        e;
    while (got < n && budget < 1000) begin
      check("out_valid in emit", {31'd0, out_valid}, 32'd1);
      check("in_ready in emit", {31'd0, in_ready}, 32'd0);
      if (junk) begin
        in_valid = 1'b1;
        in_word  = $urandom;
      end
      stalled   = stalls && ($urandom_range(0, 3) == 0);
      out_ready = !stalled;
      hold_w    = out_word;
      hold_i    = out_idx;
      if (!stalled && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard: observed=output word %h expected=no output", out_word);
        end else begin
          e = sb.pop_front();
          check($sformatf("word t=%0d", e.idx), out_word, e.word);
          check("out_idx", {26'd0, out_idx}, {26'd0, e.idx});
          check("out_last", {31'd0, out_last}, {31'd0, e.last});
        end
        got++;
      end
      @(negedge clk);
      budget++;
      if (stalled) begin
        check("stall out_word", out_word, hold_w);
        check("stall out_idx", {26'd0, out_idx}, {26'd0, hold_i});
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: observed=%0d words expected=%0d", got, n);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, " out_word"}, out_word, 32'd0);
    check({tag, " out_idx"}, {26'd0, out_idx}, 32'd0);
    check({tag, " out_last"}, {31'd0, out_last}, 32'd0);
    sb.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_check("power-on reset");

    $display("[TB] FIPS abc block");
    foreach (blk[i]) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    apply_stimulus(16, 1'b0, 1'b1);
    check_output(64, 1'b0, 1'b0);

    $display("[TB] random block with input gaps and output stalls");
    foreach (blk[i]) blk[i] = $urandom;
    apply_stimulus(16, 1'b1, 1'b0);
    check_output(64, 1'b1, 1'b1);

    $display("[TB] back-to-back blocks");
    foreach (blk[i]) blk[i] = $urandom;
    apply_stimulus(16, 1'b0, 1'b0);
    check_output(64, 1'b0, 1'b0);
    foreach (blk[i]) blk[i] = $urandom;
    apply_stimulus(16, 1'b0, 1'b0);
    check_output(64, 1'b1, 1'b0);

    $display("[TB] all-ones block");
    foreach (blk[i]) blk[i] = 32'hFFFFFFFF;
    apply_stimulus(16, 1'b0, 1'b0);
    check_output(64, 1'b0, 1'b0);

    $display("[TB] resets mid-emit and mid-load");
    foreach (blk[i]) blk[i] = $urandom;
    apply_stimulus(16, 1'b0, 1'b0);
    check_output(30, 1'b0, 1'b0);
    check("idx before reset", {26'd0, out_idx}, 32'd30);
    reset_check("reset at t=30");
    foreach (blk[i]) blk[i] = $urandom;
    apply_stimulus(7, 1'b1, 1'b0);
    reset_check("reset after 7 words");
    foreach (blk[i]) blk[i] = $urandom;
    apply_stimulus(16, 1'b0, 1'b0);
    check_output(64, 1'b1, 1'b0);

    check("scoreboard leftover", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
